// File: rtl/nn_pkg.sv
// nn_pkg: shared final-layer sizing, classifier state encoding and index-width helper
package nn_pkg;
  localparam int NN = 10;
  localparam int DATA_WIDTH = 16;
  typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/max_finder_if.sv
// max_finder_if: lane capture inputs and result handshake of the classifier stage
interface max_finder_if import nn_pkg::*; #(
  parameter int N = NN,
  parameter int DW = DATA_WIDTH,
  parameter int IW = idx_width(N)
);
  logic [N-1:0] i_valid;
  logic [N*DW-1:0] i_data;
  logic o_valid;
  logic o_ready;
  logic [IW-1:0] o_idx;
  logic [DW-1:0] o_max;
  logic busy;
  logic o_overflow;
  modport master(output i_valid, i_data, o_ready, input o_valid, o_idx, o_max, busy, o_overflow);
  modport slave(input i_valid, i_data, o_ready, output o_valid, o_idx, o_max, busy, o_overflow);
endinterface

// File: rtl/max_finder.sv
// max_finder: collects per-lane activations, serially scans for the signed maximum, hands
// the winning index/value to the host on a valid/ready handshake.
module max_finder #(
  parameter int N = nn_pkg::NN,
  parameter int DW = nn_pkg::DATA_WIDTH,
  parameter int IW = nn_pkg::idx_width(N)
) (
  input logic clk,
  input logic rst,
  max_finder_if.slave bus
);
  import nn_pkg::*;
  state_t state;
  logic [DW-1:0] lane [N];
  logic [N-1:0] mask, new_mask;
  logic [IW-1:0] cnt, run_idx, o_idx;
  logic [DW-1:0] run_max, o_max, lane0, cur;
  logic o_valid, o_overflow, accept, collecting, full, gt;
  // The acceptance edge in DONE doubles as a collect edge so images can run back to back
  assign accept = o_valid && bus.o_ready;
  assign collecting = state == COLLECT || (state == DONE && accept);
  assign new_mask = mask | bus.i_valid;
  assign full = collecting && &new_mask;
  assign lane0 = bus.i_valid[0] ? bus.i_data[DW-1:0] : lane[0];
  assign cur = lane[cnt];
  assign gt = $signed(cur) > $signed(run_max);
  assign bus.o_valid = o_valid;
  assign bus.o_idx = o_idx;
  assign bus.o_max = o_max;
  assign bus.o_overflow = o_overflow;
  assign bus.busy = state != COLLECT;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= COLLECT;
      mask <= '0;
      cnt <= '0;
      run_max <= '0;
      run_idx <= '0;
      o_valid <= 1'b0;
      o_idx <= '0;
      o_max <= '0;
      o_overflow <= 1'b0;
      for (int i = 0; i < N; i++) lane[i] <= '0;
    end else if (collecting) begin
      for (int i = 0; i < N; i++) if (bus.i_valid[i]) lane[i] <= bus.i_data[i*DW +: DW];
      if (|(mask & bus.i_valid)) o_overflow <= 1'b1;
      mask <= new_mask;
      o_valid <= 1'b0;
      state <= COLLECT;
      if (full) begin
        run_max <= lane0;
        run_idx <= '0;
        cnt <= IW'(1);
        state <= N == 1 ? DONE : SCAN;
        if (N == 1) begin
          o_valid <= 1'b1;
          o_idx <= '0;
          o_max <= lane0;
          mask <= '0;
        end
      end
    end else begin
      if (|bus.i_valid) o_overflow <= 1'b1;
      if (state == SCAN) begin
        if (gt) begin
          run_max <= cur;
          run_idx <= cnt;
        end
        if (cnt == IW'(N - 1)) begin
          state <= DONE;
          o_valid <= 1'b1;
          o_max <= gt ? cur : run_max;
          o_idx <= gt ? cnt : run_idx;
          mask <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_max_finder.sv
// tb_max_finder: table-driven full-image vectors plus directed multi-cycle sequences
module tb_max_finder;
  localparam int N = 10;
  localparam int DW = 16;
  logic clk = 0;
  logic rst = 0;
  int pass = 0;
  int total = 0;
  max_finder_if #(.N(N), .DW(DW), .IW(4)) bus();
  max_finder #(.N(N), .DW(DW), .IW(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [N*DW-1:0] data;
    logic [3:0] idx;
    logic [15:0] mx;
  } vec_t;
  vec_t tv [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else pass++;
  endtask

  function automatic logic [N*DW-1:0] img(input logic [15:0] fill, input int a, input logic [15:0] av,
                                           input int b, input logic [15:0] bv);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = i == a ? av : i == b ? bv : fill;
    return d;
  endfunction

  task automatic send(input logic [N-1:0] v, input logic [N*DW-1:0] d);
    bus.i_valid = v;
    bus.i_data = d;
    tick();
    bus.i_valid = '0;
  endtask

  task automatic wait_res(input string nm, input int lat, input logic [3:0] idx, input logic [15:0] mx);
    int n = 0;
    while (!bus.o_valid && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " latency"}, n, lat);
    chk({nm, " idx"}, bus.o_idx, idx);
    chk({nm, " max"}, bus.o_max, mx);
  endtask

  task automatic accept_res(input string nm);
    bus.o_ready = 1;
    tick();
    bus.o_ready = 0;
    chk({nm, " valid dropped"}, bus.o_valid, 0);
    chk({nm, " idle"}, bus.busy, 0);
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  initial begin
    logic [N*DW-1:0] d;
    logic stable;
    bus.i_valid = '0;
    bus.i_data = '0;
    bus.o_ready = 0;
    tick();
    tick();
    chk("reset o_valid", bus.o_valid, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset overflow", bus.o_overflow, 0);
    chk("reset o_idx", bus.o_idx, 0);
    chk("reset o_max", bus.o_max, 0);
    rst = 1;

    for (int i = 0; i < N; i++) d[i*DW +: DW] = i == 7 ? 16'h7FFF : 16'(i * 16'h0100);
    tv[0] = '{d, 4'd7, 16'h7FFF};
    tv[1] = '{img(16'h0001, 2, 16'h0400, 6, 16'h0400), 4'd2, 16'h0400};
    tv[2] = '{img(16'hFF00, 4, 16'hFFFF, 4, 16'hFFFF), 4'd4, 16'hFFFF};
    tv[3] = '{img(16'h1234, 0, 16'h1234, 0, 16'h1234), 4'd0, 16'h1234};
    tv[4] = '{img(16'h8000, 9, 16'h0100, 9, 16'h0100), 4'd9, 16'h0100};
    tv[5] = '{img(16'h7FFE, 0, 16'h7FFF, 0, 16'h7FFF), 4'd0, 16'h7FFF};
    for (int k = 0; k < 6; k++) begin
      send('1, tv[k].data);
      chk($sformatf("vec%0d busy", k), bus.busy, 1);
      wait_res($sformatf("vec%0d", k), 9, tv[k].idx, tv[k].mx);
      chk($sformatf("vec%0d overflow", k), bus.o_overflow, 0);
      accept_res($sformatf("vec%0d", k));
    end

    d = img(16'h0010, 3, 16'h0500, 3, 16'h0500);
    for (int l = N - 1; l > 0; l--) send(N'(1) << l, d);
    chk("stagger no early scan", bus.busy, 0);
    send(N'(1), d);
    chk("stagger scan starts", bus.busy, 1);
    wait_res("stagger", 9, 4'd3, 16'h0500);
    accept_res("stagger");

    send('1, tv[0].data);
    wait_res("hold", 9, 4'd7, 16'h7FFF);
    stable = 1;
    for (int c = 0; c < 20; c++) begin
      tick();
      stable &= bus.o_valid && bus.o_idx == 4'd7 && bus.o_max == 16'h7FFF && bus.busy;
    end
    chk("hold stable", stable, 1);
    send(N'(1) << 5, '0);
    chk("done drop overflow", bus.o_overflow, 1);
    chk("done drop keeps idx", bus.o_idx, 7);
    chk("done drop keeps max", bus.o_max, 16'h7FFF);
    bus.o_ready = 1;
    send('1, tv[1].data);
    bus.o_ready = 0;
    chk("b2b valid dropped", bus.o_valid, 0);
    chk("b2b busy", bus.busy, 1);
    wait_res("b2b", 9, 4'd2, 16'h0400);
    accept_res("b2b");

    do_reset();
    chk("reset clears overflow", bus.o_overflow, 0);
    d = img(16'h0001, 1, 16'h0100, 1, 16'h0100);
    send(N'(2), d);
    chk("dup first no overflow", bus.o_overflow, 0);
    d = img(16'h0001, 1, 16'h0900, 1, 16'h0900);
    send(N'(2), d);
    chk("dup overflow", bus.o_overflow, 1);
    chk("dup still collecting", bus.busy, 0);
    send(~N'(2), d);
    wait_res("dup", 9, 4'd1, 16'h0900);
    accept_res("dup");

    do_reset();
    send('1, tv[0].data);
    for (int c = 0; c < 4; c++) tick();
    chk("mid scan busy", bus.busy, 1);
    rst = 0;
    #1;
    chk("async reset o_valid", bus.o_valid, 0);
    chk("async reset busy", bus.busy, 0);
    tick();
    rst = 1;
    send(~N'(1), tv[4].data);
    chk("mask cleared", bus.busy, 0);
    send(N'(1), tv[4].data);
    wait_res("after reset", 9, 4'd9, 16'h0100);
    chk("after reset overflow", bus.o_overflow, 0);
    accept_res("after reset");

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/max_finder.md
Name: max_finder

Overview:
- Output-classification stage directly downstream of the final fully-connected layer.
- Collects the NN per-neuron activations, which may arrive in different cycles, each with its own valid bit.
- Once all lanes are captured, serially scans them for the maximum.
- Presents the winning class index and value on a valid/ready handshake for the host/display logic.

Parameters:
NN, 10, number of input lanes (neurons in the final layer)
dataWidth, 16, width of each activation, signed two's complement
idxWidth, $clog2(NN) (minimum 1), width of the result index

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
i_valid  in  NN  per-lane valid pulses, bit i qualifies lane i
i_data  in  NN*dataWidth  lane i occupies bits [i*dataWidth +: dataWidth]
o_valid  out  1  result valid, held until accepted
o_ready  in  1  consumer accepts the result when o_valid and o_ready are both high at a clock edge
o_idx  out  idxWidth  index of the maximum lane
o_max  out  dataWidth  value of the maximum lane
busy  out  1  high in SCAN and DONE
o_overflow  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (rst low, asynchronous): state=COLLECT; capture mask=0; o_valid=0, o_idx=0, o_max=0, busy=0, o_overflow=0; lane registers=0.
- Storage: NN lane registers, an NN-bit capture mask, a scan counter (idxWidth bits), a running max register and a running index register.
- COLLECT state, each edge:
  - For every i with i_valid[i]=1: lane_reg[i] <= lane i data; mask[i] <= 1.
  - If mask[i] was already 1: overwrite with the newer data and set o_overflow.
  - At the edge where the mask becomes all ones (including when every lane arrives in one cycle): go to SCAN; run_max <= lane 0; run_idx <= 0; cnt <= 1. The lane-0 value used is the one captured at that edge.
  - If NN=1: go directly to DONE with o_idx=0.
- SCAN state, each edge:
  - Compare lane_reg[cnt] > run_max, signed and strict, so ties keep the lower index.
  - If greater: update run_max and run_idx.
  - If cnt==NN-1: go to DONE, drive o_max/o_idx from the final compare, assert o_valid and clear the mask. Otherwise cnt <= cnt+1.
- Latency: o_valid rises NN-1 edges after the capture-completing edge (9 cycles for NN=10).
- DONE state:
  - o_valid, o_idx and o_max are held stable until o_valid and o_ready are both high.
  - On acceptance: o_valid <= 0 and the state returns to COLLECT.
  - i_valid bits in the acceptance cycle are captured into the new mask, so back-to-back images are supported.
- i_valid in SCAN, or in DONE without acceptance: data is dropped and o_overflow is set.
- busy = (state != COLLECT).
- o_ready while o_valid=0 has no effect.
- Reset asserted mid-SCAN or mid-DONE: everything returns to reset values immediately; the partial result is lost.
- Arithmetic: comparisons only, no width growth. The counter never exceeds NN-1.

Decomposition:
- Shared package nn_pkg holds:
  - NN and dataWidth defaults (shared with the layer instances);
  - the state enum {COLLECT, SCAN, DONE};
  - an idx_width(n) function.
- No sub-module: the single signed comparator and the lane mux stay inline. The block is roughly 150-200 lines of RTL.

Test Plan:
- All 10 lanes valid in one cycle, values 0..9 × 0x0100 with lane 7 = 0x7FFF -> o_valid rises 9 cycles later, o_idx=7, o_max=0x7FFF, o_overflow=0.
- Lanes arrive staggered one per cycle in order 9..0, lane 3 = 0x0500 and the rest 0x0010 -> no scan before lane 0 arrives; result o_idx=3, o_max=0x0500.
- Tie: lanes 2 and 6 both 0x0400, the rest 0x0001 -> o_idx=2. Negative values: all lanes 0xFF00 except lane 4 = 0xFFFF -> o_idx=4 (signed compare).
- Hold o_ready=0 for 20 cycles after o_valid -> outputs stable. A lane-5 valid during DONE -> o_overflow=1. Assert o_ready with all lanes valid in the same cycle -> next result arrives 9 cycles later.
- Duplicate valid on lane 1 during COLLECT (0x0100, then 0x0900) -> lane 1 holds 0x0900 and o_overflow=1.
- Drive rst low at cycle 4 of SCAN -> o_valid=0, busy=0, mask cleared. A fresh full image afterwards produces the correct result.
